// File: rtl/pc_epc_unit.sv
// Program-counter unit for the multicycle CPU: PC, EPC shadow register and exception-state flag.
// It supports hold, increment, aligned load, exception entry and eret. Rejected loads and erets raise one-cycle error pulses.
module pc_epc_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0040_0000,
  parameter int               STEP       = 4,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0040_0004
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] target,
  input  logic             exc_req,
  input  logic             read,
  output logic [WIDTH-1:0] pc_rdata,
  output logic [WIDTH-1:0] epc_rdata,
  output logic             in_exc,
  output logic             addr_err,
  output logic             eret_err
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_INC  = 2'b01;
  localparam logic [1:0] MODE_LOAD = 2'b10;
  localparam logic [1:0] MODE_ERET = 2'b11;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             in_exc_q, in_exc_d;
  logic             addr_err_q, addr_err_d;
  logic             eret_err_q, eret_err_d;

  // Error pulses default low, so any edge that does not re-raise them clears them.
  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    in_exc_d   = in_exc_q;
    addr_err_d = 1'b0;
    eret_err_d = 1'b0;
    if (exc_req) begin
      // A nested exception keeps the first fault's return address.
      if (!in_exc_q) epc_d = pc_q;
      pc_d     = EXC_VECTOR;
      in_exc_d = 1'b1;
    end else if (pc_en) begin
      case (mode)
        MODE_HOLD: pc_d = pc_q;
        MODE_INC:  pc_d = pc_q + STEP_W;
        MODE_LOAD: begin
          if (target[1:0] == 2'b00) pc_d = target;
          else                      addr_err_d = 1'b1;
        end
        MODE_ERET: begin
          if (in_exc_q) begin
            pc_d     = epc_q + STEP_W;
            in_exc_d = 1'b0;
          end else begin
            eret_err_d = 1'b1;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      epc_q      <= '0;
      in_exc_q   <= 1'b0;
      addr_err_q <= 1'b0;
      eret_err_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      in_exc_q   <= in_exc_d;
      addr_err_q <= addr_err_d;
      eret_err_q <= eret_err_d;
    end
  end

  assign pc_rdata  = read ? pc_q  : '0;
  assign epc_rdata = read ? epc_q : '0;
  assign in_exc    = in_exc_q;
  assign addr_err  = addr_err_q;
  assign eret_err  = eret_err_q;

endmodule

// File: tb/tb_pc_epc_unit.sv
// Directed bench for pc_epc_unit. The expected values are hand-computed constants.
module tb_pc_epc_unit;

  logic        clk;
  logic        rst_n;
  logic        pc_en;
  logic [1:0]  mode;
  logic [31:0] target;
  logic        exc_req;
  logic        read;
  logic [31:0] pc_rdata;
  logic [31:0] epc_rdata;
  logic        in_exc;
  logic        addr_err;
  logic        eret_err;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] INC  = 2'b01;
  localparam logic [1:0] LOAD = 2'b10;
  localparam logic [1:0] ERET = 2'b11;

  pc_epc_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_en     (pc_en),
    .mode      (mode),
    .target    (target),
    .exc_req   (exc_req),
    .read      (read),
    .pc_rdata  (pc_rdata),
    .epc_rdata (epc_rdata),
    .in_exc    (in_exc),
    .addr_err  (addr_err),
    .eret_err  (eret_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's controls, take the rising edge, then settle just after it.
  task automatic step(input logic en, input logic [1:0] m, input logic [31:0] t, input logic exc);
    pc_en   = en;
    mode    = m;
    target  = t;
    exc_req = exc;
    @(posedge clk);
    #1;
    pc_en   = 1'b0;
    exc_req = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    pc_en   = 1'b0;
    mode    = HOLD;
    target  = '0;
    exc_req = 1'b0;
    read    = 1'b1;
    #12;
    chk("rst_pc",       pc_rdata,  32'h0040_0000);
    chk("rst_epc",      epc_rdata, 32'h0000_0000);
    chk("rst_in_exc",   32'(in_exc),   32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_eret_err", 32'(eret_err), 32'd0);
    read = 1'b0;
    #1;
    chk("gate_pc",  pc_rdata,  32'h0);
    chk("gate_epc", epc_rdata, 32'h0);
    read = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // hold and increment
    step(1'b1, HOLD, 32'h0, 1'b0);
    chk("hold_pc", pc_rdata, 32'h0040_0000);
    for (int i = 0; i < 3; i++) step(1'b1, INC, 32'h0, 1'b0);
    chk("inc3_pc", pc_rdata, 32'h0040_000C);
    step(1'b1, LOAD, 32'hFFFF_FFFC, 1'b0);
    chk("load_top", pc_rdata, 32'hFFFF_FFFC);
    step(1'b1, INC, 32'h0, 1'b0);
    chk("inc_wrap", pc_rdata, 32'h0000_0000);
    step(1'b0, INC, 32'h0, 1'b0);
    chk("en0_held", pc_rdata, 32'h0000_0000);

    // load and misalignment
    step(1'b1, LOAD, 32'h0040_0100, 1'b0);
    chk("load_pc",      pc_rdata, 32'h0040_0100);
    chk("load_no_err",  32'(addr_err), 32'd0);
    step(1'b1, LOAD, 32'h0040_0102, 1'b0);
    chk("misal_pc",     pc_rdata, 32'h0040_0100);
    chk("misal_err",    32'(addr_err), 32'd1);
    step(1'b0, HOLD, 32'h0, 1'b0);
    chk("misal_clr",    32'(addr_err), 32'd0);

    // exception round trip
    step(1'b1, LOAD, 32'h0040_0020, 1'b0);
    step(1'b0, HOLD, 32'h0, 1'b1);
    chk("exc_pc",     pc_rdata,  32'h0040_0004);
    chk("exc_epc",    epc_rdata, 32'h0040_0020);
    chk("exc_in_exc", 32'(in_exc), 32'd1);
    step(1'b0, ERET, 32'h0, 1'b0);
    chk("eret_en0_pc", pc_rdata, 32'h0040_0004);
    step(1'b1, ERET, 32'h0, 1'b0);
    chk("eret_pc",     pc_rdata,  32'h0040_0024);
    chk("eret_in_exc", 32'(in_exc), 32'd0);
    chk("eret_epc",    epc_rdata, 32'h0040_0020);
    chk("eret_no_err", 32'(eret_err), 32'd0);

    // priority and nesting
    step(1'b1, LOAD, 32'h0040_0020, 1'b0);
    step(1'b1, LOAD, 32'h0040_0100, 1'b1);
    chk("prio_pc",  pc_rdata,  32'h0040_0004);
    chk("prio_epc", epc_rdata, 32'h0040_0020);
    step(1'b1, INC, 32'h0, 1'b0);
    chk("handler_inc", pc_rdata, 32'h0040_0008);
    step(1'b0, HOLD, 32'h0, 1'b1);
    chk("nest_pc",     pc_rdata,  32'h0040_0004);
    chk("nest_epc",    epc_rdata, 32'h0040_0020);
    chk("nest_in_exc", 32'(in_exc), 32'd1);
    step(1'b1, ERET, 32'h0, 1'b0);
    chk("nest_eret_pc", pc_rdata, 32'h0040_0024);
    step(1'b1, ERET, 32'h0, 1'b0);
    chk("bad_eret_pc",  pc_rdata, 32'h0040_0024);
    chk("bad_eret_err", 32'(eret_err), 32'd1);
    chk("bad_eret_exc", 32'(in_exc), 32'd0);
    step(1'b1, INC, 32'h0, 1'b0);
    chk("eret_err_clr", 32'(eret_err), 32'd0);
    chk("post_inc_pc",  pc_rdata, 32'h0040_0028);

    // async reset inside the handler
    step(1'b0, HOLD, 32'h0, 1'b1);
    chk("pre_rst_epc",    epc_rdata, 32'h0040_0028);
    chk("pre_rst_in_exc", 32'(in_exc), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc",     pc_rdata,  32'h0040_0000);
    chk("arst_epc",    epc_rdata, 32'h0000_0000);
    chk("arst_in_exc", 32'(in_exc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, INC, 32'h0, 1'b0);
    chk("post_rst_inc", pc_rdata, 32'h0040_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
